// File: rtl/sw_input_conditioner_pkg.sv
// Shared configuration for the switch/pushbutton input conditioner.
package sw_input_conditioner_pkg;

    // Number of board switch/pushbutton pins conditioned.
    localparam int unsigned SW_WIDTH            = 5;
    // 20 ms at 50 MHz.
    localparam int unsigned SW_DEBOUNCE_CYCLES  = 1000000;
    // Stability counter width; must hold SW_DEBOUNCE_CYCLES-1.
    localparam int unsigned SW_CNT_W            = 20;
    // Index of the pushbutton bit that gets press/release pulses.
    localparam int unsigned SW_PB_BIT           = 0;
    // Short debounce window so simulations finish quickly.
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, stability counter and debounced level register.
module sw_debounce_bit
    import sw_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = SW_CNT_W
) (
    input  logic Clock_pin,
    input  logic Resetn_pin,
    input  logic sw_raw,
    output logic sw_clean,
    output logic cnt_active
);

    // Last count value before a new level is accepted.
    localparam logic [CNT_W-1:0] TermCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             clean_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the asynchronous pin into the Clock_pin domain.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles of disagreement; accept the new level once the window fills.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else if (sync2_q == clean_q) begin
            cnt_q   <= '0;
        end else if (cnt_q == TermCnt) begin
            // Clearing here keeps the counter from ever wrapping.
            clean_q <= sync2_q;
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign sw_clean   = clean_q;
    assign cnt_active = (cnt_q != '0);

endmodule

// File: rtl/sw_input_conditioner.sv
// Synchronises and debounces the board switches; emits press/release pulses for the pushbutton.
module sw_input_conditioner
    import sw_input_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = SW_CNT_W,
    parameter int unsigned PB_BIT          = SW_PB_BIT
) (
    input  logic             Clock_pin,
    input  logic             Resetn_pin,
    input  logic [WIDTH-1:0] SW_raw,
    output logic [WIDTH-1:0] SW_clean,
    output logic             Press_pulse,
    output logic             Release_pulse,
    output logic             Busy
);

    logic [WIDTH-1:0] cnt_active;
    logic             pb_prev_q;
    logic             press_q;
    logic             release_q;
    logic             busy_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .Clock_pin (Clock_pin),
            .Resetn_pin(Resetn_pin),
            .sw_raw    (SW_raw[i]),
            .sw_clean  (SW_clean[i]),
            .cnt_active(cnt_active[i])
        );
    end

    // Registered edge detect on the pushbutton level plus the pending-change flag.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            pb_prev_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            pb_prev_q <= SW_clean[PB_BIT];
            press_q   <= SW_clean[PB_BIT] & ~pb_prev_q;
            release_q <= ~SW_clean[PB_BIT] & pb_prev_q;
            busy_q    <= |cnt_active;
        end
    end

    assign Press_pulse   = press_q;
    assign Release_pulse = release_q;
    assign Busy          = busy_q;

endmodule
